// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction, ALU, write-back and preload signals of the issue block.
// Latency: none, wiring only.
// Backpressure: instr_valid/instr_ready handshake; the other groups are strobes or levels.
interface alu_issue_if;
  // Instruction handshake
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  // External combinational ALU
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [7:0]  alu_select;
  logic [15:0] alu_out;
  logic        alu_carry;
  // Write-back and status
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        illegal;
  logic        carry_flag;
  // Register preload
  logic        pre_we;
  logic [3:0]  pre_addr;
  logic [15:0] pre_data;

  // Environment side: offers instructions, models the ALU, preloads registers
  modport master (
    output instr_valid, instr, alu_out, alu_carry, pre_we, pre_addr, pre_data,
    input  instr_ready, alu_a, alu_b, alu_select, wb_valid, wb_rd, wb_data,
           illegal, carry_flag
  );

  // Issue block side
  modport slave (
    input  instr_valid, instr, alu_out, alu_carry, pre_we, pre_addr, pre_data,
    output instr_ready, alu_a, alu_b, alu_select, wb_valid, wb_rd, wb_data,
           illegal, carry_flag
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: single-issue front end for an external combinational ALU with a 16x16-bit register file.
// Latency: accept edge N -> wb_valid in cycle N+3 (N+2 for 0xB immediates when ALU_ISSUE_CI8_EN is defined).
// Backpressure: instr_ready only in IDLE, one instruction per 4 cycles; preload honoured only in IDLE without an accept.
module alu_issue (
  input  logic       clk,
  input  logic       rst_n,
  alu_issue_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t      state_q;
  logic [15:0] instr_q;
  logic        ready_q;
  logic        illegal_q;
  logic        wb_valid_q;
  logic        wb_alu_q;       // write-back came from the ALU, so it updates carry_flag
  logic        res_carry_q;
  logic        carry_flag_q;
  logic [15:0] alu_a_q;
  logic [15:0] alu_b_q;
  logic [7:0]  alu_sel_q;
  logic [3:0]  wb_rd_q;
  logic [15:0] wb_data_q;
  logic [15:0] regs_q [16];

  logic        accept;
  logic        in_legal;
  logic        q_ci8;
  logic        pre_wr_en;
  logic [3:0]  rs_q;
  logic [3:0]  rd_q;
`ifdef ALU_ISSUE_CI8_EN
  logic [15:0] ci8_imm;
`endif

  // Ops the attached ALU implements
  function automatic logic op_supported(input logic [7:0] op);
    logic ok;
    ok = 1'b0;
    if (op[7:3] == 5'b01110) ok = 1'b1;           // 0x70-0x77
    else if (op[7:2] == 6'b011000) ok = 1'b1;     // 0x60-0x63
    else begin
      case (op)
        8'h50, 8'h51, 8'h52: ok = 1'b1;
        8'h10:               ok = 1'b1;
        8'h32, 8'h33:        ok = 1'b1;
        default:             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  assign rs_q = instr_q[7:4];
  assign rd_q = instr_q[3:0];

  // Handshake, decode of the offered and captured words, preload qualification
  always_comb begin
    accept = bus.instr_valid && ready_q;
`ifdef ALU_ISSUE_CI8_EN
    in_legal = op_supported(bus.instr[15:8]) || (bus.instr[15:12] == 4'hB);
    q_ci8    = (instr_q[15:12] == 4'hB);
    ci8_imm  = {{8{instr_q[11]}}, instr_q[11:4]};
`else
    in_legal = op_supported(bus.instr[15:8]);
    q_ci8    = 1'b0;
`endif
    // Preload never races an instruction: it only lands while idle and not accepting
    pre_wr_en = (state_q == IDLE) && bus.pre_we && !accept;
  end

  // Issue FSM with all externally visible outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      ready_q      <= 1'b0;
      illegal_q    <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_alu_q     <= 1'b0;
      res_carry_q  <= 1'b0;
      carry_flag_q <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
    end else begin
      // Strobes last exactly one cycle unless a state below re-asserts them
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            instr_q   <= bus.instr;
            ready_q   <= 1'b0;
            // Raised here so the pulse is visible during the READ cycle
            illegal_q <= !in_legal;
            state_q   <= READ;
          end else begin
            // Also the path that raises ready in the first cycle after reset
            ready_q <= 1'b1;
          end
        end
        READ: begin
          if (illegal_q) begin
            // Unsupported op: drop it, leave operands, registers and carry untouched
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else if (q_ci8) begin
`ifdef ALU_ISSUE_CI8_EN
            // Immediate load bypasses the ALU and skips EXEC
            wb_rd_q    <= rd_q;
            wb_data_q  <= ci8_imm;
            wb_alu_q   <= 1'b0;
            wb_valid_q <= 1'b1;
            state_q    <= WB;
`endif
          end else begin
            alu_a_q   <= regs_q[rs_q];
            alu_b_q   <= regs_q[rd_q];
            alu_sel_q <= instr_q[15:8];
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          // ALU result settles during EXEC from the operands registered in READ
          wb_data_q   <= bus.alu_out;
          res_carry_q <= bus.alu_carry;
          wb_rd_q     <= rd_q;
          wb_alu_q    <= 1'b1;
          wb_valid_q  <= 1'b1;
          state_q     <= WB;
        end
        WB: begin
          if (wb_alu_q) carry_flag_q <= res_carry_q;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Register file: preload while idle, write-back at the end of WB (write-back listed last so it wins)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      if (pre_wr_en) regs_q[bus.pre_addr] <= bus.pre_data;
      if (state_q == WB) regs_q[wb_rd_q] <= wb_data_q;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_select  = alu_sel_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.illegal     = illegal_q;
  assign bus.carry_flag  = carry_flag_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed bench for alu_issue with an ALU model and a write-back scoreboard.
// Latency: checks N+3 ALU write-back, N+2 illegal return and immediate write-back.
// Backpressure: holds instr_valid across a busy window to check the 4-cycle issue rate.
module tb_alu_issue;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_if bus ();

  alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total  = 0;
  int passed = 0;
  logic [15:0] m_regs [16];
  logic        m_carry;
  logic [19:0] sb_q [$];   // {rd, data}

  // Reference ALU: {carry, result}
  function automatic logic [16:0] alu_fn(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    r = '0;
    if (op[7:3] == 5'b01110) r = {1'b0, a} + {1'b0, b};
    else if (op[7:2] == 6'b011000) r = {1'b0, a} - {1'b0, b};
    else begin
      case (op)
        8'h50:   r = {1'b0, a & b};
        8'h51:   r = {1'b0, a | b};
        8'h52:   r = {1'b0, a ^ b};
        8'h10:   r = {1'b0, a};
        8'h32:   r = {1'b0, ~a};
        8'h33:   r = {a, 1'b0};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  always_comb {bus.alu_carry, bus.alu_out} = alu_fn(bus.alu_select, bus.alu_a, bus.alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  // Record the expected write-back of a legal instruction and update the model
  task automatic model_issue(input logic [15:0] w);
    logic [16:0] r;
    logic [3:0]  rs;
    logic [3:0]  rd;
    rs = w[7:4];
    rd = w[3:0];
`ifdef ALU_ISSUE_CI8_EN
    if (w[15:12] == 4'hB) begin
      r = {1'b0, {8{w[11]}}, w[11:4]};
      sb_q.push_back({rd, r[15:0]});
      m_regs[rd] = r[15:0];
      return;
    end
`endif
    r = alu_fn(w[15:8], m_regs[rs], m_regs[rd]);
    sb_q.push_back({rd, r[15:0]});
    m_regs[rd] = r[15:0];
    m_carry    = r[16];
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle N+1
  task automatic send(input logic [15:0] w);
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    bus.pre_we   = 1'b1;
    bus.pre_addr = a;
    bus.pre_data = d;
    @(negedge clk);
    bus.pre_we = 1'b0;
    m_regs[a]  = d;
  endtask

  // Waits (bounded) for wb_valid from cycle offset cur, checks latency and pops the scoreboard
  task automatic expect_wb(input string tag, input int cur, input int lat);
    int k;
    logic [19:0] e;
    k = cur;
    while (bus.wb_valid !== 1'b1 && k < lat + 3) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'(1'b1));
    if (bus.wb_valid === 1'b1) begin
      chk({tag, "_latency"}, k, lat);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'(e[19:16]));
        chk({tag, "_wb_data"}, 32'(bus.wb_data), 32'(e[15:0]));
      end else begin
        chk({tag, "_scoreboard"}, sb_q.size(), 1);
      end
    end
  endtask

  // Read a register through the operand bus with a pass-through op (rs = rd = i)
  task automatic rd_reg(input logic [3:0] i);
    logic [15:0] w;
    w = {8'h10, i, i};
    model_issue(w);
    send(w);
    @(negedge clk);
    chk($sformatf("rd_r%0d_alu_a", i), 32'(bus.alu_a), 32'(m_regs[i]));
    expect_wb($sformatf("rd_r%0d", i), 2, 3);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.pre_we      = 1'b0;
    bus.pre_addr    = '0;
    bus.pre_data    = '0;
    rst_n           = 1'b0;
    m_carry         = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.instr_ready), 32'(1'b0));
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'(1'b0));
    chk("rst_illegal", 32'(bus.illegal), 32'(1'b0));
    chk("rst_alu_a", 32'(bus.alu_a), 32'(16'h0));
    chk("rst_alu_select", 32'(bus.alu_select), 32'(8'h0));
    chk("rst_wb_data", 32'(bus.wb_data), 32'(16'h0));
    chk("rst_carry", 32'(bus.carry_flag), 32'(1'b0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.instr_ready), 32'(1'b1));

    // Add 8 + 2 into r1
    preload(4'd2, 16'h0008);
    preload(4'd1, 16'h0002);
    model_issue(16'h7021);
    send(16'h7021);
    chk("add_ready_read", 32'(bus.instr_ready), 32'(1'b0));
    chk("add_illegal_read", 32'(bus.illegal), 32'(1'b0));
    @(negedge clk);
    chk("add_select_exec", 32'(bus.alu_select), 32'(8'h70));
    chk("add_alu_a", 32'(bus.alu_a), 32'(16'h0008));
    chk("add_alu_b", 32'(bus.alu_b), 32'(16'h0002));
    expect_wb("add", 2, 3);
    chk("add_wb_data_lit", 32'(bus.wb_data), 32'(16'h000A));
    @(negedge clk);
    chk("add_carry", 32'(bus.carry_flag), 32'(1'b0));
    chk("add_ready_idle", 32'(bus.instr_ready), 32'(1'b1));

    // Add with carry out: 0x0001 + 0xFFFF
    preload(4'd1, 16'hFFFF);
    preload(4'd2, 16'h0001);
    model_issue(16'h7021);
    send(16'h7021);
    expect_wb("addc", 1, 3);
    chk("addc_wb_data_lit", 32'(bus.wb_data), 32'(16'h0000));
    @(negedge clk);
    chk("addc_carry", 32'(bus.carry_flag), 32'(m_carry));
    chk("addc_carry_lit", 32'(bus.carry_flag), 32'(1'b1));

    // Unsupported op 0x40: illegal pulse, no write-back, r1 and carry untouched
    preload(4'd1, 16'h5A5A);
    send(16'h4021);
    chk("ill_pulse", 32'(bus.illegal), 32'(1'b1));
    chk("ill_ready_read", 32'(bus.instr_ready), 32'(1'b0));
    @(negedge clk);
    chk("ill_pulse_end", 32'(bus.illegal), 32'(1'b0));
    chk("ill_idle_n2", 32'(bus.instr_ready), 32'(1'b1));
    chk("ill_no_wb", 32'(bus.wb_valid), 32'(1'b0));
    chk("ill_carry_kept", 32'(bus.carry_flag), 32'(1'b1));
    rd_reg(4'd1);

    // Preload ignored when an instruction is accepted and when not in IDLE
    bus.pre_we   = 1'b1;
    bus.pre_addr = 4'd5;
    bus.pre_data = 16'h1234;
    model_issue(16'h3256);
    send(16'h3256);
    bus.pre_addr = 4'd6;
    bus.pre_data = 16'hBEEF;
    @(negedge clk);
    chk("pre_block_alu_a", 32'(bus.alu_a), 32'(m_regs[5]));
    expect_wb("not", 2, 3);
    bus.pre_we = 1'b0;
    @(negedge clk);
    rd_reg(4'd5);
    rd_reg(4'd6);

    // Back-to-back words with instr_valid held
    model_issue(16'h6056);
    model_issue(16'h3365);
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h6056;
    @(negedge clk);
    bus.instr = 16'h3365;
    chk("b2b_ready_read", 32'(bus.instr_ready), 32'(1'b0));
    @(negedge clk);
    chk("b2b_ready_exec", 32'(bus.instr_ready), 32'(1'b0));
    @(negedge clk);
    chk("b2b_ready_wb", 32'(bus.instr_ready), 32'(1'b0));
    expect_wb("b2b1", 3, 3);
    @(negedge clk);
    chk("b2b_ready_n4", 32'(bus.instr_ready), 32'(1'b1));
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("b2b_second_accepted", 32'(bus.instr_ready), 32'(1'b0));
    expect_wb("b2b2", 5, 7);
    @(negedge clk);
    chk("b2b_carry", 32'(bus.carry_flag), 32'(m_carry));

    // Immediate load (0xB prefix)
`ifdef ALU_ISSUE_CI8_EN
    model_issue(16'hB7F3);
    send(16'hB7F3);
    expect_wb("ci8_pos", 1, 2);
    chk("ci8_pos_lit", 32'(bus.wb_data), 32'(16'h007F));
    @(negedge clk);
    chk("ci8_carry_kept", 32'(bus.carry_flag), 32'(m_carry));
    model_issue(16'hB803);
    send(16'hB803);
    expect_wb("ci8_neg", 1, 2);
    chk("ci8_neg_lit", 32'(bus.wb_data), 32'(16'hFF80));
    @(negedge clk);
    rd_reg(4'd3);
`else
    send(16'hB7F3);
    chk("ci8_off_illegal", 32'(bus.illegal), 32'(1'b1));
    @(negedge clk);
    chk("ci8_off_ready", 32'(bus.instr_ready), 32'(1'b1));
    chk("ci8_off_no_wb", 32'(bus.wb_valid), 32'(1'b0));
`endif

    // Reset dropped during EXEC abandons the instruction
    preload(4'd7, 16'h0777);
    send(16'h7021);
    @(negedge clk);
    chk("rexec_select", 32'(bus.alu_select), 32'(8'h70));
    rst_n = 1'b0;
    #1;
    chk("rexec_wb_valid", 32'(bus.wb_valid), 32'(1'b0));
    chk("rexec_alu_a", 32'(bus.alu_a), 32'(16'h0));
    chk("rexec_alu_b", 32'(bus.alu_b), 32'(16'h0));
    chk("rexec_alu_select", 32'(bus.alu_select), 32'(8'h0));
    chk("rexec_ready", 32'(bus.instr_ready), 32'(1'b0));
    chk("rexec_carry", 32'(bus.carry_flag), 32'(1'b0));
    chk("rexec_wb_data", 32'(bus.wb_data), 32'(16'h0));
    @(negedge clk);
    rst_n   = 1'b1;
    m_carry = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.wb_valid !== 1'b0) seen++;
    end
    chk("rexec_no_wb_after", seen, 0);
    for (int i = 0; i < 16; i++) rd_reg(4'(i));

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
